// File: rtl/detection_event_counter.sv
// Turns detector pulses into single events, counts them with sticky overflow and
// a threshold alarm, and serves count snapshots over a four-phase req/ack handshake.
// Build option: define DETCNT_SATURATE_EN to saturate at the maximum count instead of wrapping.
module detection_event_counter #(
  parameter int CNT_W  = 8,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             detected,
  input  logic             clr,
  input  logic             rd_req,
  output logic             rd_ack,
  output logic [CNT_W-1:0] rd_data,
  output logic [CNT_W-1:0] count,
  output logic             alarm,
  output logic             overflow
);

  typedef enum logic {
    HS_IDLE = 1'b0,
    HS_ACK  = 1'b1
  } hs_state_e;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(THRESH);

  logic             det_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] rd_data_q, rd_data_d;
  hs_state_e        state_q, state_d;
  logic             det_event;
  logic             capture;

  // Only the rising edge of a held detection level is an event.
  assign det_event = detected & ~det_q;

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (det_event) begin
      if (count_q == CNT_MAX) begin
        ovf_d = 1'b1;
`ifdef DETCNT_SATURATE_EN
        count_d = CNT_MAX;
`else
        count_d = '0;
`endif
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  // Handshake next-state: a capture needs a pass through ACK with rd_req low before it can recur.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HS_IDLE: if (rd_req)  state_d = HS_ACK;
      HS_ACK:  if (!rd_req) state_d = HS_IDLE;
      default: state_d = HS_IDLE;
    endcase
  end

  // Handshake outputs; the snapshot takes the count before this cycle's clr/event update.
  always_comb begin
    rd_ack    = (state_q == HS_ACK);
    capture   = (state_q == HS_IDLE) && rd_req;
    rd_data_d = capture ? count_q : rd_data_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      det_q     <= 1'b0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      rd_data_q <= '0;
      state_q   <= HS_IDLE;
    end else begin
      det_q     <= detected;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      rd_data_q <= rd_data_d;
      state_q   <= state_d;
    end
  end

  assign count    = count_q;
  assign overflow = ovf_q;
  assign rd_data  = rd_data_q;
  assign alarm    = (count_q >= THRESH_C);

endmodule

// File: doc/detection_event_counter.md
Name: detection_event_counter

Overview:
Downstream consumer of the serial pattern detector's `detected` output.
- Converts each detection into a single event, whether the pulse lasts one cycle or several.
- Keeps a running event count with a sticky overflow flag and a threshold alarm.
- Lets a host take a coherent count snapshot over a four-phase req/ack handshake.
- Sits between the detector FSM and the status/host interface logic.

Parameters:
- CNT_W, 8, width of event counter and snapshot bus (2..16).
- THRESH, 4, alarm threshold; legal range 1..2^CNT_W-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- detected  input  1  pulse from the pattern detector.
- clr  input  1  synchronous clear of count, overflow and alarm.
- rd_req  input  1  host snapshot request, level, four-phase.
- rd_ack  output  1  snapshot valid / handshake acknowledge.
- rd_data  output  CNT_W  captured count, stable while rd_ack=1.
- count  output  CNT_W  live event count.
- alarm  output  1  high while count >= THRESH.
- overflow  output  1  sticky, set on increment past 2^CNT_W-1.

Behaviour:
- Reset (rst=1 at a clk edge): count=0, overflow=0, rd_ack=0, rd_data=0, det_d=0, handshake FSM=IDLE. alarm is therefore 0.
- Event qualify: det_d <= detected every cycle. event = detected & ~det_d. A high level lasting N cycles counts as exactly one event.
- Increment latency: an event at edge k is visible on count after edge k (1 cycle).
- alarm = (count >= THRESH), combinational from the count register. It follows count with no extra latency and falls when clr takes effect.
- clr has priority over a same-cycle event. The event is discarded, count=0, overflow=0. det_d still updates normally, so a held `detected` is not recounted after clr.
- Wrap (default): at count = 2^CNT_W-1, an event sets count to 0 and overflow to 1. overflow stays 1 until clr or rst.
- Handshake FSM, 2 states:
  - IDLE: rd_ack=0. On rd_req=1: rd_data <= count (the pre-update value of that cycle), rd_ack <= 1, go to ACK.
  - ACK: rd_ack=1 and rd_data frozen. Counting continues. When rd_req=0: rd_ack <= 0, go to IDLE.
  - rd_req held high after a completed handshake does not retrigger; the FSM must pass through ACK with rd_req=0 first.
- Capture concurrent with clr or event: the snapshot holds the value before that cycle's update.
- rst mid-handshake: rd_ack=0 after the edge, FSM=IDLE, rd_data=0. The requester must drop and re-raise rd_req.
- clr does not affect the handshake FSM or rd_data.

Optional Feature:
DETCNT_SATURATE_EN
- Defined: count saturates at 2^CNT_W-1. An event at max leaves count at max and sets overflow.
- Undefined: wrap-around as described above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset, then 3 one-cycle `detected` pulses separated by 0 → count=3 one cycle after each pulse; alarm=0.
- A 5-cycle-long `detected` pulse → count increments by exactly 1. A fourth distinct pulse (count=4) → alarm=1 the cycle count becomes 4.
- CNT_W=4, 16 events, wrap build → count=0, overflow=1. Saturate build → count=15, overflow=1. clr → count=0, overflow=0, alarm=0.
- clr and a rising `detected` in the same cycle → count=0 afterwards. Holding `detected` high afterwards → no further increment.
- count=7, raise rd_req while an event arrives in the same cycle → rd_ack=1 next cycle with rd_data=7 and count=8. rd_data stays 7 under further events. rd_req=0 → rd_ack=0 next cycle. rd_req held high across the ack cycle → no second capture.
- rst asserted while rd_ack=1 and count=9 → next cycle rd_ack=0, rd_data=0, count=0, overflow=0.
